dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Shares the single data-memory port of the pipeline MEM stage between the pipeline (priority requester) and a secondary loader/debug port (memory initialisation, inspection). The pipeline owns the port whenever it issues a load or store; the loader is served in idle MEM cycles. If the loader waits too long, a starvation counter forces a one-cycle pipeline stall so the loader can proceed. The block sits between the EX/MEM register outputs and the data memory; its stall output feeds the hazard/stall logic.

## Interface
- STARVE_LIMIT, 8: cycles the loader may wait (range 1..255) before a forced stall.
- CNT_W, 8: width of the starvation counter and of the optional statistics counters.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- p_read, p_write  in  1 each  pipeline load/store request for the current MEM cycle.
- p_addr, p_wdata  in  32 each  pipeline address and store data.
- p_rdata  out  32  load data to the pipeline; equals mem_rdata.
- p_stall  out  1  freezes PC, IF/ID, ID/EX and EX/MEM; the MEM/WB register is loaded with a bubble.
- l_req  in  1  loader request; must be held with l_we, l_addr and l_wdata stable until l_ack.
- l_we  in  1  1 = write, 0 = read.
- l_addr, l_wdata  in  32 each  loader address and write data.
- l_ack  out  1  one-cycle pulse indicating the access is complete.
- l_rdata  out  32  registered read data, valid while l_ack = 1 and held until the next ack.
- mem_addr, mem_wdata  out  32 each  to data memory.
- mem_read, mem_write  out  1 each  to data memory. Reads are combinational; writes take effect on the clk edge.
- mem_rdata  in  32  from data memory.
- loader_grant  out  1  1 in any cycle in which the loader drives the memory.

## Operation
- States: ARB, FORCE, ACK. Reset state: ARB.
- ARB, with p_read|p_write = 1: the pipeline drives the memory.
  - If l_req = 1, wait_cnt increments.
  - If wait_cnt = STARVE_LIMIT-1 and l_req = 1, the next state is FORCE.
- ARB, with the pipeline idle and l_req = 1: the loader drives the memory (loader_grant = 1).
  - mem_write = l_we; mem_read = ~l_we.
  - l_rdata captures mem_rdata on a read; it is unchanged on a write.
  - Next state is ACK.
- ARB, with no requests: memory signals are driven from the pipeline inputs, so read = write = 0. wait_cnt holds.
- FORCE: p_stall = 1 and loader_grant = 1. The loader access executes exactly as in ARB. The pipeline inputs are ignored and are re-presented unchanged next cycle because of the stall. Next state is ACK.
- ACK:
  - l_ack = 1 and wait_cnt clears.
  - The pipeline drives the memory; a pipeline access is allowed in this cycle.
  - l_req is ignored. Next state is ARB.
  - If l_req is still high in ARB, it is treated as a new request.
- p_stall is 1 only in FORCE.
- wait_cnt saturates and never wraps. It clears on any loader grant.

## Timing
- Reset values (asynchronous, immediate):
  - state = ARB, wait_cnt = 0, l_rdata = 0, l_ack = 0, p_stall = 0, loader_grant = 0.
  - mem_read and mem_write follow the pipeline inputs.
- Pipeline latency: zero added cycles; the memory is driven combinationally in the same cycle.
- Loader latency:
  - Idle MEM stage: grant in cycle N, l_ack in cycle N+1.
  - Continuously busy pipeline: request seen at cycle 0, FORCE at cycle STARVE_LIMIT, l_ack at cycle STARVE_LIMIT+1.
- STARVE_LIMIT = 1: FORCE follows the first blocked cycle.
- Pipeline access and loader request in the same cycle in ARB: the pipeline always wins unless the limit is reached on that edge.
- Reset asserted mid-access:
  - Any loader access in progress is abandoned and no ack is issued.
  - A memory write is prevented only if rst falls before the edge; the memory itself is not reset.
- l_req dropped before ack (protocol violation): if the drop happens in ARB, wait_cnt clears and no access occurs. A FORCE already entered completes.

## Configuration
- DMEM_ARB_STATS_EN defined adds two output ports, each CNT_W wide, reset to 0, and saturating:
  - stat_loader_acc: increments on each l_ack.
  - stat_forced: increments on each FORCE entry.
- DMEM_ARB_STATS_EN undefined: the ports and counters are absent; all other behaviour is identical.

## Test plan
- Idle pipeline; loader writes 0xDEADBEEF to addr 0x40, then reads addr 0x40 -> each access: loader_grant for 1 cycle, then l_ack the next cycle; the read returns l_rdata = 0xDEADBEEF; p_stall stays 0.
- STARVE_LIMIT = 4; back-to-back pipeline loads; loader read raised at cycle 0 -> FORCE at cycle 4 with p_stall = 1 for exactly one cycle; l_ack at cycle 5; the pipeline load presented at cycle 4 completes correctly at cycle 5.
- Pipeline store of 0x12345678 to 0x80 in the same cycle as a loader read of 0x80 (limit not reached) -> the store executes first; the loader is granted on the next idle cycle and returns 0x12345678.
- rst driven low while in FORCE -> asynchronously: p_stall = 0, l_ack = 0, state = ARB; no l_ack after release; the pipeline resumes with no stall.
- l_req held high across ACK with changed address -> exactly two grants and two l_acks; a grant never occurs in the ACK cycle.
- With DMEM_ARB_STATS_EN defined, after the above -> stat_forced and stat_loader_acc match the counts; both saturate at 2^CNT_W-1 under a long loop.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: the pipeline has priority and the loader is served in idle MEM cycles.
// A starved loader forces a one-cycle pipeline stall. Define DMEM_ARB_STATS_EN to add the statistics counters.
module dmem_arbiter #(
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             p_read,
  input  logic             p_write,
  input  logic [31:0]      p_addr,
  input  logic [31:0]      p_wdata,
  output logic [31:0]      p_rdata,
  output logic             p_stall,
  input  logic             l_req,
  input  logic             l_we,
  input  logic [31:0]      l_addr,
  input  logic [31:0]      l_wdata,
  output logic             l_ack,
  output logic [31:0]      l_rdata,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             mem_read,
  output logic             mem_write,
  input  logic [31:0]      mem_rdata,
  output logic             loader_grant
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_loader_acc,
  output logic [CNT_W-1:0] stat_forced
`endif
);

  localparam logic [1:0] ARB   = 2'd0;
  localparam logic [1:0] FORCE = 2'd1;
  localparam logic [1:0] ACK   = 2'd2;
  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(STARVE_LIMIT - 1);

  logic [1:0]       state, nextState;
  logic [CNT_W-1:0] waitCnt;
  logic             pipeReq, loaderGrant, blocked;

  assign pipeReq = p_read | p_write;
  assign blocked = (state == ARB) && pipeReq && l_req;

  // Grant is masked by reset so a held reset never lets the loader touch memory.
  assign loaderGrant = rst && ((state == FORCE) || ((state == ARB) && !pipeReq && l_req));

  always_comb begin
    mem_addr     = loaderGrant ? l_addr  : p_addr;
    mem_wdata    = loaderGrant ? l_wdata : p_wdata;
    mem_read     = loaderGrant ? !l_we   : p_read;
    mem_write    = loaderGrant ? l_we    : p_write;
    p_rdata      = mem_rdata;
    p_stall      = (state == FORCE);
    l_ack        = (state == ACK);
    loader_grant = loaderGrant;
  end

  always_comb begin
    nextState = ARB;
    case (state)
      ARB: begin
        if (!pipeReq && l_req)                nextState = ACK;
        else if (blocked && waitCnt == LIMIT_M1) nextState = FORCE;
        else                                  nextState = ARB;
      end
      FORCE:   nextState = ACK;
      ACK:     nextState = ARB;
      default: nextState = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ARB;
      waitCnt <= '0;
      l_rdata <= '0;
    end else begin
      state <= nextState;
      // A dropped request in ARB abandons the accumulated wait.
      if (loaderGrant || state == ACK || (state == ARB && !l_req))
        waitCnt <= '0;
      else if (blocked && waitCnt != '1)
        waitCnt <= waitCnt + CNT_W'(1);
      if (loaderGrant && !l_we)
        l_rdata <= mem_rdata;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_loader_acc <= '0;
      stat_forced     <= '0;
    end else begin
      if (state == ACK && stat_loader_acc != '1)
        stat_loader_acc <= stat_loader_acc + CNT_W'(1);
      if (state != FORCE && nextState == FORCE && stat_forced != '1)
        stat_forced <= stat_forced + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: per-cycle vector table plus hand-written starvation/reset/hold sequences.
// Built with STARVE_LIMIT = 4; the statistics checks compile only with DMEM_ARB_STATS_EN.
module tb_dmem_arbiter;
  localparam int LIMIT = 4;
  localparam int CW    = 8;

  logic clk = 1'b0, rst;
  logic p_read, p_write, l_req, l_we;
  logic [31:0] p_addr, p_wdata, l_addr, l_wdata;
  logic [31:0] p_rdata, l_rdata, mem_addr, mem_wdata, mem_rdata;
  logic p_stall, l_ack, mem_read, mem_write, loader_grant;
`ifdef DMEM_ARB_STATS_EN
  logic [CW-1:0] stat_loader_acc, stat_forced;
`endif

  int total = 0, bad = 0;
  logic [31:0] mem [0:255];

  always #5 clk = ~clk;

  dmem_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .p_read(p_read), .p_write(p_write), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_rdata(p_rdata), .p_stall(p_stall),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_ack(l_ack), .l_rdata(l_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata), .loader_grant(loader_grant)
`ifdef DMEM_ARB_STATS_EN
    , .stat_loader_acc(stat_loader_acc), .stat_forced(stat_forced)
`endif
  );

  // Bench-side data memory: combinational read, write on the edge, preset while reset is held.
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 | i;
    end else if (mem_write) begin
      mem[mem_addr[9:2]] <= mem_wdata;
    end
  end

  typedef struct {
    logic pr, pw; logic [31:0] pa, pd;
    logic lr, lw; logic [31:0] la, ld;
    logic eStall, eGrant, eAck, eRd, eWr; logic [31:0] eAddr;
    logic chkRd; logic [31:0] eRdata;
  } vec_t;

  function automatic vec_t mkv(logic pr, logic pw, logic [31:0] pa, logic [31:0] pd,
                               logic lr, logic lw, logic [31:0] la, logic [31:0] ld,
                               logic eStall, logic eGrant, logic eAck, logic eRd, logic eWr,
                               logic [31:0] eAddr, logic chkRd, logic [31:0] eRdata);
    vec_t v;
    v.pr = pr; v.pw = pw; v.pa = pa; v.pd = pd;
    v.lr = lr; v.lw = lw; v.la = la; v.ld = ld;
    v.eStall = eStall; v.eGrant = eGrant; v.eAck = eAck; v.eRd = eRd; v.eWr = eWr;
    v.eAddr = eAddr; v.chkRd = chkRd; v.eRdata = eRdata;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic setIn(input logic pr, input logic pw, input logic [31:0] pa, input logic [31:0] pd,
                       input logic lr, input logic lw, input logic [31:0] la, input logic [31:0] ld);
    p_read = pr; p_write = pw; p_addr = pa; p_wdata = pd;
    l_req = lr; l_we = lw; l_addr = la; l_wdata = ld;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  vec_t vt [10];
  int grants, acks;

  initial begin
    vt[0] = mkv(0,0,0,0, 1,1,32'h40,32'hDEADBEEF, 0,1,0,0,1, 32'h40, 0,0);
    vt[1] = mkv(0,0,0,0, 1,1,32'h40,32'hDEADBEEF, 0,0,1,0,0, 32'h0,  1,32'h0);
    vt[2] = mkv(0,0,0,0, 1,0,32'h40,0,            0,1,0,1,0, 32'h40, 0,0);
    vt[3] = mkv(0,0,0,0, 1,0,32'h40,0,            0,0,1,0,0, 32'h0,  1,32'hDEADBEEF);
    vt[4] = mkv(0,0,0,0, 0,0,0,0,                 0,0,0,0,0, 32'h0,  0,0);
    vt[5] = mkv(1,0,32'h100,0, 0,0,0,0,           0,0,0,1,0, 32'h100,0,0);
    vt[6] = mkv(0,1,32'h80,32'h12345678, 1,0,32'h80,0, 0,0,0,0,1, 32'h80, 0,0);
    vt[7] = mkv(0,0,0,0, 1,0,32'h80,0,            0,1,0,1,0, 32'h80, 0,0);
    vt[8] = mkv(0,0,0,0, 1,0,32'h80,0,            0,0,1,0,0, 32'h0,  1,32'h12345678);
    vt[9] = mkv(0,0,0,0, 0,0,0,0,                 0,0,0,0,0, 32'h0,  0,0);

    // Reset: outputs idle, loader blocked, memory strobes follow the pipeline.
    rst = 1'b0;
    setIn(0,0,0,0, 1,1,32'h40,32'h5);
    #2;
    chk("rstStall", p_stall, 0);
    chk("rstAck", l_ack, 0);
    chk("rstGrant", loader_grant, 0);
    chk("rstWrite", mem_write, 0);
    chk("rstRdata", l_rdata, 0);
    p_read = 1'b1; p_addr = 32'h100;
    #1 chk("rstMemRead", mem_read, 1);
    @(posedge clk); cyc();
    rst = 1'b1;
    setIn(0,0,0,0, 0,0,0,0);
    cyc();

    for (int i = 0; i < 10; i++) begin
      setIn(vt[i].pr, vt[i].pw, vt[i].pa, vt[i].pd, vt[i].lr, vt[i].lw, vt[i].la, vt[i].ld);
      @(negedge clk);
      chk($sformatf("v%0d.stall", i), p_stall, vt[i].eStall);
      chk($sformatf("v%0d.grant", i), loader_grant, vt[i].eGrant);
      chk($sformatf("v%0d.ack", i), l_ack, vt[i].eAck);
      chk($sformatf("v%0d.rd", i), mem_read, vt[i].eRd);
      chk($sformatf("v%0d.wr", i), mem_write, vt[i].eWr);
      chk($sformatf("v%0d.addr", i), mem_addr, vt[i].eAddr);
      chk($sformatf("v%0d.prdata", i), p_rdata, mem[vt[i].eAddr[9:2]]);
      if (vt[i].chkRd) chk($sformatf("v%0d.lrdata", i), l_rdata, vt[i].eRdata);
      cyc();
    end

    // Busy pipeline starves the loader: FORCE at cycle LIMIT, ack at LIMIT+1.
    setIn(1,0,32'h100,0, 1,0,32'h40,0);
    for (int c = 0; c < LIMIT; c++) begin
      p_addr = 32'h100 + 4*c;
      @(negedge clk);
      chk("starveNoStall", p_stall, 0);
      chk("starvePipeAddr", mem_addr, 32'h100 + 4*c);
      cyc();
    end
    p_addr = 32'h110;
    @(negedge clk);
    chk("forceStall", p_stall, 1);
    chk("forceGrant", loader_grant, 1);
    chk("forceAddr", mem_addr, 32'h40);
    chk("forceRead", mem_read, 1);
    cyc();
    @(negedge clk);
    chk("postForceStall", p_stall, 0);
    chk("postForceAck", l_ack, 1);
    chk("replayAddr", mem_addr, 32'h110);
    chk("replayData", p_rdata, 32'hA000_0044);
    chk("forceLrdata", l_rdata, 32'hDEADBEEF);
    cyc();
    l_req = 1'b0;
    @(negedge clk);
    chk("afterAckStall", p_stall, 0);
    cyc();

    // Reset asserted while in FORCE: immediate abandon, no late ack.
    setIn(1,0,32'h100,0, 1,0,32'h40,0);
    repeat (LIMIT) cyc();
    @(negedge clk);
    chk("force2Stall", p_stall, 1);
    rst = 1'b0; l_req = 1'b0;
    #1;
    chk("asyncStall", p_stall, 0);
    chk("asyncAck", l_ack, 0);
    chk("asyncGrant", loader_grant, 0);
    chk("asyncPipeAddr", mem_addr, 32'h100);
    @(posedge clk); #1 rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("postRstAck", l_ack, 0);
      chk("postRstStall", p_stall, 0);
      chk("postRstRdata", l_rdata, 0);
      cyc();
    end

    // Request dropped in ARB clears the wait count: FORCE needs LIMIT fresh blocked cycles.
    setIn(1,0,32'h100,0, 1,0,32'h40,0);
    repeat (2) cyc();
    l_req = 1'b0;
    cyc();
    l_req = 1'b1;
    for (int c = 0; c < LIMIT; c++) begin
      @(negedge clk);
      chk("dropNoStall", p_stall, 0);
      cyc();
    end
    @(negedge clk);
    chk("dropForce", p_stall, 1);
    cyc();
    @(negedge clk);
    chk("dropAck", l_ack, 1);
    chk("dropLrdata", l_rdata, 32'hA000_0010);
    cyc();
    setIn(0,0,0,0, 0,0,0,0);
    cyc();

    // Request held across ACK with a new address: two grants, two acks, never overlapping.
    grants = 0; acks = 0;
    setIn(0,0,0,0, 1,1,32'h44,32'h11111111);
    for (int c = 0; c < 6; c++) begin
      if (c == 1) begin l_addr = 32'h48; l_wdata = 32'h22222222; end
      if (c == 4) l_req = 1'b0;
      @(negedge clk);
      grants += int'(loader_grant);
      acks   += int'(l_ack);
      chk("grantInAck", loader_grant & l_ack, 0);
      cyc();
    end
    chk("heldGrants", grants, 2);
    chk("heldAcks", acks, 2);
    chk("heldMem44", mem[17], 32'h11111111);
    chk("heldMem48", mem[18], 32'h22222222);

`ifdef DMEM_ARB_STATS_EN
    chk("statAcc", stat_loader_acc, 3);
    chk("statForced", stat_forced, 1);
    // Permanent starvation: one forced access every LIMIT+2 cycles, enough to saturate both counters.
    setIn(1,0,32'h100,0, 1,0,32'h40,0);
    repeat (260 * (LIMIT + 2)) cyc();
    chk("statAccSat", stat_loader_acc, 8'hFF);
    chk("statForcedSat", stat_forced, 8'hFF);
    setIn(0,0,0,0, 0,0,0,0);
    cyc();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
